// File: rtl/maxpool2_c32.sv
// 2x2 stride-2 signed max-pool over a raster stream of CH-wide pixel vectors.
// A horizontal pair is reduced into a line buffer on even rows and finished on odd rows.
module maxpool2_c32_lane #(
    parameter int N = 16
) (
    input  logic [N-1:0] hreg,
    input  logic [N-1:0] din,
    input  logic [N-1:0] lb,
    output logic [N-1:0] hmax,
    output logic [N-1:0] pmax
);
    always_comb begin
        hmax = ($signed(din) > $signed(hreg)) ? din : hreg;
        pmax = ($signed(lb) > $signed(hmax)) ? lb : hmax;
    end
endmodule

module maxpool2_c32 #(
    parameter int N          = 16,
    parameter int CH         = 32,
    parameter int INPUT_SIZE = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              input_vld,
    input  logic [CH*N-1:0]   input_din,
    output logic [CH*N-1:0]   pool_dout,
    output logic              pool_dout_vld,
    output logic              pool_dout_end
);
    localparam int HW = INPUT_SIZE / 2;
    // One extra bit keeps col[CW-1:1] a legal slice even for INPUT_SIZE=2.
    localparam int CW = $clog2(INPUT_SIZE + 1);
    localparam logic [CW-1:0] LAST = CW'(INPUT_SIZE - 1);

    logic [CW-1:0] col, row;
    logic [CW-2:0] idx;
    logic          clr, acc, col_last, row_last;

    logic [CH-1:0][N-1:0] din_v, hreg, lb_rd, hmax, pmax;
    logic [CH-1:0][N-1:0] lb [HW];

    assign clr      = rst | ~ce;
    assign acc      = input_vld & ce & ~rst;
    assign col_last = (col == LAST);
    assign row_last = (row == LAST);
    assign idx      = col[CW-1:1];
    assign din_v    = input_din;
    assign lb_rd    = lb[idx];

    for (genvar g = 0; g < CH; g++) begin : g_lane
        maxpool2_c32_lane #(.N(N)) u_lane (
            .hreg (hreg[g]),
            .din  (din_v[g]),
            .lb   (lb_rd[g]),
            .hmax (hmax[g]),
            .pmax (pmax[g])
        );
    end

    // Data storage is never cleared; every entry is written before it is read in a frame.
    always_ff @(posedge clk) begin
        if (acc) begin
            if (!col[0])
                hreg <= din_v;
            else if (!row[0])
                lb[idx] <= hmax;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            col           <= '0;
            row           <= '0;
            pool_dout     <= '0;
            pool_dout_vld <= 1'b0;
            pool_dout_end <= 1'b1;
        end else begin
            pool_dout_vld <= 1'b0;
            if (acc) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (col[0] && row[0]) begin
                    pool_dout     <= pmax;
                    pool_dout_vld <= 1'b1;
                end
                if (col == '0 && row == '0)
                    pool_dout_end <= 1'b0;
                if (col_last && row_last)
                    pool_dout_end <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_maxpool2_c32.sv
// Directed, table-driven bench for maxpool2_c32: ramp, signed-max, gaps, aborts, back-to-back frames.
module tb_maxpool2_c32;
    localparam int N  = 16;
    localparam int CH = 32;
    localparam int S  = 6;
    localparam int NB = S * S;

    logic            clk = 1'b0;
    logic            rst, ce, input_vld;
    logic [CH*N-1:0] input_din;
    logic [CH*N-1:0] pool_dout;
    logic            pool_dout_vld, pool_dout_end;

    maxpool2_c32 #(.N(N), .CH(CH), .INPUT_SIZE(S)) dut (
        .clk           (clk),
        .rst           (rst),
        .ce            (ce),
        .input_vld     (input_vld),
        .input_din     (input_din),
        .pool_dout     (pool_dout),
        .pool_dout_vld (pool_dout_vld),
        .pool_dout_end (pool_dout_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH*N-1:0] din;
        logic            exp_vld;
        logic            exp_end;
        logic [CH*N-1:0] exp_dout;
    } vec_t;

    vec_t            vecs [NB];
    logic [CH*N-1:0] last_dout;
    int              tests = 0;
    int              fails = 0;

    task automatic chk(input string name, input logic [CH*N-1:0] act, input logic [CH*N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic rand_din();
        for (int c = 0; c < CH; c++) input_din[c*N +: N] = N'($urandom);
    endtask

    // kind 0: ramp, channel c = r*6+col+c*100. kind 1: lo everywhere, hi at one rotating spot per window.
    task automatic build(input int kind, input logic [N-1:0] lo, input logic [N-1:0] hi);
        for (int r = 0; r < S; r++)
            for (int cl = 0; cl < S; cl++) begin
                int k, p, pos;
                k   = r * S + cl;
                p   = ((r / 2) * (S / 2) + (cl / 2)) % 4;
                pos = (r % 2) * 2 + (cl % 2);
                vecs[k].exp_vld  = (r % 2 == 1) && (cl % 2 == 1);
                vecs[k].exp_end  = (k == NB - 1);
                vecs[k].exp_dout = '0;
                for (int c = 0; c < CH; c++) begin
                    if (kind == 0) begin
                        vecs[k].din[c*N +: N] = N'(r * S + cl + c * 100);
                        vecs[k].exp_dout[c*N +: N] = N'((2*(r/2)+1) * S + (2*(cl/2)+1) + c * 100);
                    end else begin
                        vecs[k].din[c*N +: N] = (pos == p) ? hi : lo;
                        vecs[k].exp_dout[c*N +: N] = hi;
                    end
                end
            end
    endtask

    // Drive the first nbeats of the table, with 0..maxgap idle cycles after each beat.
    task automatic run_frame(input int nbeats, input int maxgap, input string tag);
        for (int k = 0; k < nbeats; k++) begin
            input_vld = 1'b1;
            input_din = vecs[k].din;
            @(posedge clk); #1;
            chk({tag, "_vld"}, {511'b0, pool_dout_vld}, {511'b0, vecs[k].exp_vld});
            chk({tag, "_end"}, {511'b0, pool_dout_end}, {511'b0, vecs[k].exp_end});
            if (vecs[k].exp_vld) last_dout = vecs[k].exp_dout;
            chk({tag, "_dout"}, pool_dout, last_dout);
            input_vld = 1'b0;
            rand_din();
            repeat ($urandom_range(maxgap, 0)) begin
                @(posedge clk); #1;
                chk({tag, "_gap_vld"}, {511'b0, pool_dout_vld}, 512'b0);
                chk({tag, "_gap_end"}, {511'b0, pool_dout_end}, {511'b0, vecs[k].exp_end});
                chk({tag, "_gap_dout"}, pool_dout, last_dout);
            end
        end
    endtask

    // Abort with either ce low or rst high for 3 cycles while beats keep arriving.
    task automatic abort(input logic use_rst, input string tag);
        if (use_rst) rst = 1'b1; else ce = 1'b0;
        input_vld = 1'b1;
        repeat (3) begin
            rand_din();
            @(posedge clk); #1;
            chk({tag, "_vld"}, {511'b0, pool_dout_vld}, 512'b0);
            chk({tag, "_end"}, {511'b0, pool_dout_end}, {511'b0, 1'b1});
            chk({tag, "_dout"}, pool_dout, 512'b0);
        end
        rst = 1'b0; ce = 1'b1; input_vld = 1'b0;
        last_dout = '0;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; input_vld = 1'b1; rand_din();
        repeat (3) begin
            @(posedge clk); #1;
            chk("reset_vld", {511'b0, pool_dout_vld}, 512'b0);
            chk("reset_end", {511'b0, pool_dout_end}, {511'b0, 1'b1});
            chk("reset_dout", pool_dout, 512'b0);
            rand_din();
        end
        rst = 1'b0; input_vld = 1'b0;
        last_dout = '0;

        build(0, '0, '0);
        run_frame(NB, 0, "ramp");

        build(1, 16'h8000, 16'h7FFF);
        run_frame(NB, 0, "smax_ext");
        build(1, 16'hFFFB, 16'hFFFD);
        run_frame(NB, 0, "smax_neg");

        build(0, '0, '0);
        run_frame(NB, 4, "gap");

        run_frame(20, 0, "pre_ce_abort");
        abort(1'b0, "ce_abort");
        run_frame(NB, 0, "post_ce");

        run_frame(20, 1, "pre_rst_abort");
        abort(1'b1, "rst_abort");
        run_frame(NB, 0, "post_rst");

        run_frame(NB, 0, "b2b_a");
        run_frame(NB, 0, "b2b_b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end
endmodule

// File: doc/maxpool2_c32.md
# maxpool2_c32

2×2, stride-2 max-pooling stage directly downstream of the 6-input pointwise convolution layer. It consumes the layer's raster-ordered stream of OUTPUT_CHANNEL-wide pixel vectors, one vector per `input_vld` beat. It emits a (INPUT_SIZE/2)×(INPUT_SIZE/2) pooled map in raster order, with per-channel signed maximum. The valid/end handshake style matches the convolution layers, so the block chains into the next layer without glue logic.

## Interface
- `N`, 16, per-channel data width; two's-complement fixed point.
- `CH`, 32, channels per pixel vector; equals the upstream OUTPUT_CHANNEL.
- `INPUT_SIZE`, 6, input map height and width. Must be even and ≥2.

- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ce`  in  1  enable. Low has the same effect as `rst`.
- `input_vld`  in  1  a pixel vector is present on `input_din` this cycle.
- `input_din`  in  CH*N  channel i occupies bits [(i+1)*N-1:i*N].
- `pool_dout`  out  CH*N  pooled vector, same channel packing as `input_din`.
- `pool_dout_vld`  out  1  single-cycle strobe; `pool_dout` is valid.
- `pool_dout_end`  out  1  high when idle or frame complete; low while a frame is in progress.

## Operation
- Counters `col` and `row`, each 0..INPUT_SIZE-1, advance only on accepted beats. An accepted beat is `input_vld`=1 with `ce`=1 and `rst`=0.
- `col` increments on each beat. At INPUT_SIZE-1 it wraps to 0 and `row` increments. At (INPUT_SIZE-1, INPUT_SIZE-1) both wrap to 0, which marks the end of the frame.
- Even `col`: latch the vector into the horizontal register `hreg`.
- Odd `col`: form `hmax` = per-channel signed max(`hreg`, `input_din`).
  - Even `row`: write `hmax` into the line buffer entry `col>>1`. The buffer has INPUT_SIZE/2 entries of CH*N bits.
  - Odd `row`: register per-channel signed max(`linebuf[col>>1]`, `hmax`) into `pool_dout` and pulse `pool_dout_vld`.
- Comparisons are signed and N bits wide. There is no saturation and no width growth. On equal values either operand may pass, since the result is identical.
- Outputs per frame: (INPUT_SIZE/2)². For the defaults that is 9.
- The line buffer and `hreg` are not cleared by reset. Each entry is always written before it is read within a frame.
- There is no backpressure. The downstream stage must accept every strobe.

## Timing
- Reset values (also applied whenever `ce`=0): `pool_dout`=0, `pool_dout_vld`=0, `pool_dout_end`=1, `col`=`row`=0.
- Latency: `pool_dout_vld` is high in the cycle after the edge that samples a beat with odd `row` and odd `col`. The strobe lasts exactly one cycle.
- `pool_dout` holds its value between strobes.
- Full rate: back-to-back beats are supported every cycle. Arbitrary idle gaps between beats are allowed and do not change results.
- `pool_dout_end` goes low at the edge that samples the first beat of a frame (`row`=`col`=0).
- `pool_dout_end` goes high at the edge that samples the last beat. It therefore rises in the same cycle as the final `pool_dout_vld`.
- Back-to-back frames: `pool_dout_end` is high for exactly one cycle between frames. The set and clear events never fall on the same edge.
- Reset or `ce`=0 mid-frame: the partial frame is discarded and no further strobes come from it. The next accepted beat is treated as (0,0).
- `input_vld` while `ce`=0 or `rst`=1 is ignored.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with random `input_din` and `input_vld`=1.
  - Required: `pool_dout`=0, `pool_dout_vld`=0, `pool_dout_end`=1 throughout.
- Ramp frame: send 36 back-to-back beats with channel c = r*6+col+c*100.
  - Required: 9 strobes; the k-th output at (i,j) equals (2i+1)*6+(2j+1)+c*100. The first output is 7+100c and the last is 35+100c.
  - Required: each strobe occurs 1 cycle after its odd/odd beat; `pool_dout_end` falls after beat 0 and rises with strobe 9.
- Signed max: all inputs are 16'h8000 except one 16'h7FFF per window at a rotating position.
  - Required: every output is 16'h7FFF.
  - Repeat with values -5 and a single -3 per window; required output is -3.
- Gapped input: the ramp frame with 0–4 random idle cycles between beats.
  - Required: outputs identical to the ramp case, with each strobe still exactly 1 cycle after its trigger beat.
- Abort: pull `ce` low, or assert `rst`, after 20 beats, then send a full ramp frame.
  - Required: no strobes during the abort and `pool_dout_end`=1.
  - Required: the new frame yields the correct 9 outputs.
- Two frames back-to-back with no gap.
  - Required: 18 correct strobes, and `pool_dout_end` is high for exactly one cycle between the frames.
